countdown_timer_mmss: RTL and testbench

COUNTDOWN_TIMER_MMSS -- requirements
Module: countdown_timer_mmss

---
 rtl/countdown_timer_mmss.sv | 95 +++++++++
 tb/tb_countdown_timer_mmss.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_mmss.sv
// countdown_timer_mmss: MM:SS BCD countdown controller with tick prescaler and door interlock
module countdown_timer_mmss #(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] din_mt,
  input  logic [3:0] din_mu,
  input  logic [3:0] din_st,
  input  logic [3:0] din_su,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic       running,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t     r_state;
  logic [3:0] r_mt, r_mu, r_st, r_su;
  logic [7:0] r_pre;
  logic       r_running, r_done;
  logic       w_b0, w_b1, w_b2, w_is_zero, w_dec_zero, w_wrap, w_start_ok;
  logic [3:0] w_dmt, w_dmu, w_dst, w_dsu;
  logic [3:0] w_lmt, w_lmu, w_lst, w_lsu;
  logic [7:0] w_pre_inc;
  assign w_b0       = r_su == 4'd0;
  assign w_b1       = w_b0 && r_st == 4'd0;
  assign w_b2       = w_b1 && r_mu == 4'd0;
  assign w_dsu      = w_b0 ? 4'd9 : r_su - 4'd1;
  assign w_dst      = w_b0 ? (r_st == 4'd0 ? 4'd5 : r_st - 4'd1) : r_st;
  assign w_dmu      = w_b1 ? (r_mu == 4'd0 ? 4'd9 : r_mu - 4'd1) : r_mu;
  assign w_dmt      = w_b2 ? r_mt - 4'd1 : r_mt;
  assign w_is_zero  = {r_mt, r_mu, r_st, r_su} == 16'd0;
  assign w_dec_zero = {w_dmt, w_dmu, w_dst, w_dsu} == 16'd0;
  assign w_lmt      = din_mt > 4'd9 ? 4'd9 : din_mt;
  assign w_lmu      = din_mu > 4'd9 ? 4'd9 : din_mu;
  assign w_lst      = din_st > 4'd5 ? 4'd5 : din_st;
  assign w_lsu      = din_su > 4'd9 ? 4'd9 : din_su;
  assign w_pre_inc  = r_pre + 8'd1;
  assign w_wrap     = w_pre_inc == 8'(TICKS_PER_SEC);
  assign w_start_ok = (r_state == IDLE || r_state == PAUSE) && door_closed && !w_is_zero;
  // Controller: commands resolved in priority order stop, door open, load, start, tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      {r_mt, r_mu, r_st, r_su} <= 16'd0;
      r_pre     <= 8'd0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_running <= 1'b0;
        if (r_state == RUN) begin
          r_state <= PAUSE;
        end else begin
          r_state <= IDLE;
          {r_mt, r_mu, r_st, r_su} <= 16'd0;
        end
      end else if (!door_closed && r_state == RUN) begin
        r_state   <= PAUSE;
        r_running <= 1'b0;
      end else if (load && r_state != RUN) begin
        r_state <= IDLE;
        {r_mt, r_mu, r_st, r_su} <= {w_lmt, w_lmu, w_lst, w_lsu};
      end else if (start && w_start_ok) begin
        r_state   <= RUN;
        r_running <= 1'b1;
        r_pre     <= 8'd0;
      end else if (tick && r_state == RUN) begin
        r_pre <= w_wrap ? 8'd0 : w_pre_inc;
        if (w_wrap) begin
          {r_mt, r_mu, r_st, r_su} <= {w_dmt, w_dmu, w_dst, w_dsu};
          if (w_dec_zero) begin
            r_state   <= DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end
        end
      end
    end
  end
  assign min_t   = r_mt;
  assign min_u   = r_mu;
  assign sec_t   = r_st;
  assign sec_u   = r_su;
  assign running = r_running;
  assign done    = r_done;
endmodule

// File: tb/tb_countdown_timer_mmss.sv
// tb_countdown_timer_mmss: scoreboard bench, two instances (1 and 2 ticks per second) against a seconds-count model
module tb_countdown_timer_mmss;
  localparam int TPS_A = 1;
  localparam int TPS_B = 2;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, door_closed = 1'b1;
  logic [3:0] din_mt = 4'd0, din_mu = 4'd0, din_st = 4'd0, din_su = 4'd0;
  logic [3:0] a_mt, a_mu, a_st, a_su, b_mt, b_mu, b_st, b_su;
  logic a_run, a_done, b_run, b_done;
  typedef struct {int st; int secs; int pre; bit done;} mdl_t;
  typedef struct {logic [17:0] a; logic [17:0] b;} exp_t;
  mdl_t ma, mb;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  countdown_timer_mmss #(.TICKS_PER_SEC(TPS_A)) u_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
    .din_mt(din_mt), .din_mu(din_mu), .din_st(din_st), .din_su(din_su),
    .start(start), .stop(stop), .door_closed(door_closed),
    .min_t(a_mt), .min_u(a_mu), .sec_t(a_st), .sec_u(a_su), .running(a_run), .done(a_done));
  countdown_timer_mmss #(.TICKS_PER_SEC(TPS_B)) u_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
    .din_mt(din_mt), .din_mu(din_mu), .din_st(din_st), .din_su(din_su),
    .start(start), .stop(stop), .door_closed(door_closed),
    .min_t(b_mt), .min_u(b_mu), .sec_t(b_st), .sec_u(b_su), .running(b_run), .done(b_done));
  // Free-running clock
  always #5 clk = ~clk;
  function automatic int clamp_secs();
    int mt = din_mt > 9 ? 9 : int'(din_mt);
    int mu = din_mu > 9 ? 9 : int'(din_mu);
    int st = din_st > 5 ? 5 : int'(din_st);
    int su = din_su > 9 ? 9 : int'(din_su);
    return (mt * 10 + mu) * 60 + st * 10 + su;
  endfunction
  // Remaining time held as a plain seconds count; one-second decrement is just secs-1
  function automatic mdl_t step(mdl_t m, int tps);
    m.done = 1'b0;
    if (stop) begin
      if (m.st == S_RUN) m.st = S_PAUSE;
      else begin m.st = S_IDLE; m.secs = 0; end
    end else if (!door_closed && m.st == S_RUN) m.st = S_PAUSE;
    else if (load && m.st != S_RUN) begin m.st = S_IDLE; m.secs = clamp_secs(); end
    else if (start && (m.st == S_IDLE || m.st == S_PAUSE) && door_closed && m.secs != 0) begin
      m.st = S_RUN; m.pre = 0;
    end else if (tick && m.st == S_RUN) begin
      m.pre++;
      if (m.pre == tps) begin
        m.pre = 0; m.secs--;
        if (m.secs == 0) begin m.st = S_DONE; m.done = 1'b1; end
      end
    end
    return m;
  endfunction
  function automatic logic [17:0] view(mdl_t m);
    int mm = m.secs / 60;
    int ss = m.secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), m.st == S_RUN, m.done};
  endfunction
  function automatic void chk(string name, logic [17:0] got, logic [17:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h (mmss=%h run=%b done=%b) expected %h (mmss=%h run=%b done=%b)",
                  name, got, got[17:2], got[1], got[0], exp, exp[17:2], exp[1], exp[0]);
  endfunction
  task automatic go(input bit t, input bit ld, input bit sa, input bit sp, input bit dc);
    tick = t; load = ld; start = sa; stop = sp; door_closed = dc;
    ma = step(ma, TPS_A);
    mb = step(mb, TPS_B);
    q.push_back('{view(ma), view(mb)});
    @(negedge clk);
  endtask
  task automatic ld_time(input logic [3:0] mt, input logic [3:0] mu, input logic [3:0] st, input logic [3:0] su);
    din_mt = mt; din_mu = mu; din_st = st; din_su = su;
    go(0, 1, 0, 0, 1);
  endtask
  function automatic void model_reset();
    ma = '{S_IDLE, 0, 0, 1'b0};
    mb = '{S_IDLE, 0, 0, 1'b0};
  endfunction
  // Monitor: after every edge compare both instances with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("scoreboard a", {a_mt, a_mu, a_st, a_su, a_run, a_done}, e.a);
        chk("scoreboard b", {b_mt, b_mu, b_st, b_su, b_run, b_done}, e.b);
      end
    end
  end
  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  // Stimulus: directed scenarios, then randomized traffic
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset a", {a_mt, a_mu, a_st, a_su, a_run, a_done}, 18'd0);
    chk("reset b", {b_mt, b_mu, b_st, b_su, b_run, b_done}, 18'd0);
    rst_n = 1'b1;
    @(negedge clk);
    ld_time(0, 0, 0, 3);
    go(0, 0, 1, 0, 1);
    go(1, 0, 0, 0, 1);
    chk("tps1 first tick", {a_mt, a_mu, a_st, a_su, a_run, a_done}, {16'h0002, 2'b10});
    go(1, 0, 0, 0, 1);
    go(1, 0, 0, 0, 1);
    chk("tps1 done edge", {a_mt, a_mu, a_st, a_su, a_run, a_done}, {16'h0000, 2'b01});
    go(0, 0, 0, 0, 1);
    chk("tps1 done low after", {a_mt, a_mu, a_st, a_su, a_run, a_done}, 18'd0);
    go(0, 0, 0, 1, 1);
    ld_time(0, 0, 0, 2);
    go(0, 0, 1, 0, 1);
    go(1, 0, 0, 0, 1);
    chk("tps2 one tick", {b_mt, b_mu, b_st, b_su, b_run, b_done}, {16'h0002, 2'b10});
    go(1, 0, 0, 0, 1);
    go(1, 0, 0, 0, 1);
    go(1, 0, 0, 0, 1);
    chk("tps2 done", {b_mt, b_mu, b_st, b_su, b_run, b_done}, {16'h0000, 2'b01});
    go(0, 0, 0, 1, 1);
    ld_time(1, 0, 0, 0);
    go(0, 0, 1, 0, 1);
    go(1, 0, 0, 0, 1);
    chk("borrow 10:00", {a_mt, a_mu, a_st, a_su, a_run, a_done}, {16'h0959, 2'b10});
    go(0, 0, 0, 1, 1);
    ld_time(0, 1, 0, 0);
    go(0, 0, 1, 0, 1);
    go(1, 0, 0, 0, 1);
    chk("borrow 01:00", {a_mt, a_mu, a_st, a_su, a_run, a_done}, {16'h0059, 2'b10});
    ld_time(0, 0, 0, 7);
    chk("load ignored in run", {a_mt, a_mu, a_st, a_su, a_run, a_done}, {16'h0059, 2'b10});
    go(0, 0, 0, 1, 1);
    go(0, 0, 0, 1, 1);
    go(0, 0, 1, 0, 1);
    chk("start at 00:00 ignored", {a_mt, a_mu, a_st, a_su, a_run, a_done}, 18'd0);
    ld_time(12, 7, 8, 15);
    chk("clamp 97:59", {a_mt, a_mu, a_st, a_su, a_run, a_done}, {16'h9759, 2'b00});
    din_mt = 0; din_mu = 0; din_st = 1; din_su = 0;
    go(0, 1, 1, 0, 1);
    chk("load beats start", {a_mt, a_mu, a_st, a_su, a_run, a_done}, {16'h0010, 2'b00});
    go(0, 0, 1, 0, 1);
    go(1, 0, 0, 0, 1);
    go(1, 0, 0, 0, 1);
    go(1, 0, 0, 0, 0);
    chk("door open pause", {a_mt, a_mu, a_st, a_su, a_run, a_done}, {16'h0008, 2'b00});
    go(0, 0, 1, 0, 0);
    chk("start door open", {a_mt, a_mu, a_st, a_su, a_run, a_done}, {16'h0008, 2'b00});
    go(0, 0, 1, 0, 1);
    chk("resume", {a_mt, a_mu, a_st, a_su, a_run, a_done}, {16'h0008, 2'b10});
    go(0, 0, 0, 1, 1);
    chk("stop to pause", {a_mt, a_mu, a_st, a_su, a_run, a_done}, {16'h0008, 2'b00});
    go(0, 0, 0, 1, 1);
    chk("stop clears", {a_mt, a_mu, a_st, a_su, a_run, a_done}, 18'd0);
    ld_time(0, 0, 0, 5);
    go(0, 0, 1, 0, 1);
    go(1, 0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset a", {a_mt, a_mu, a_st, a_su, a_run, a_done}, 18'd0);
    chk("async reset b", {b_mt, b_mu, b_st, b_su, b_run, b_done}, 18'd0);
    tick = 1'b1;
    @(negedge clk);
    chk("held reset no done", {a_mt, a_mu, a_st, a_su, a_run, a_done}, 18'd0);
    model_reset();
    rst_n = 1'b1;
    repeat (3) go(1, 0, 1, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) begin
        din_mt = 4'($urandom_range(15)); din_mu = 4'($urandom_range(15));
        din_st = 4'($urandom_range(15)); din_su = 4'($urandom_range(15));
      end else begin
        din_mt = 4'd0; din_mu = 4'd0;
        din_st = 4'($urandom_range(1)); din_su = 4'($urandom_range(9));
      end
      go($urandom_range(1) == 1, $urandom_range(15) == 0, $urandom_range(5) == 0,
         $urandom_range(39) == 0, $urandom_range(19) != 0);
    end
    go(0, 0, 0, 0, 1);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
